dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_resp_if.sv | 22 ++
 rtl/dmem_resp_tx_fifo.sv | 49 ++++
 rtl/dmem_resp.sv | 143 ++++++++++++++
 tb/tb_dmem_resp.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Address map, MMIO register offsets and CON_STAT bit layout shared by the data-memory responder.
package dmem_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

    localparam logic [3:0] OFF_CON_TX   = 4'h0;
    localparam logic [3:0] OFF_CON_STAT = 4'h4;
    localparam logic [3:0] OFF_MTIME_LO = 4'h8;
    localparam logic [3:0] OFF_MTIME_HI = 4'hC;

    localparam int unsigned STAT_FULL      = 0;
    localparam int unsigned STAT_EMPTY     = 1;
    localparam int unsigned STAT_COUNT_LSB = 2;
    localparam int unsigned STAT_COUNT_W   = 5;
    localparam int unsigned STAT_OVF       = 7;

    typedef enum logic [2:0] {
        RegNone,
        RegRam,
        RegConTx,
        RegConStat,
        RegMtimeLo,
        RegMtimeHi
    } region_e;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Data-memory bus plus console byte stream between a core and dmem_resp.
interface dmem_resp_if;
    logic        dmem_read;
    logic [3:0]  dmem_writeb;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_fault;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;

    modport master (
        output dmem_read, dmem_writeb, dmem_addr, dmem_wdata, con_ready,
        input  dmem_rdata, dmem_fault, con_data, con_valid
    );

    modport slave (
        input  dmem_read, dmem_writeb, dmem_addr, dmem_wdata, con_ready,
        output dmem_rdata, dmem_fault, con_data, con_valid
    );
endinterface

// File: rtl/dmem_resp_tx_fifo.sv
// Console TX byte FIFO; a push while full is accepted only when a pop happens in the same cycle.
module tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [7:0]             din,
    input  logic                   pop,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   count_q;
    logic          do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage is deliberately not reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/dmem_resp.sv
// Zero-latency data RAM with optional console/timer MMIO block (enabled by DMEM_MMIO_EN).
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic        clk,
    input logic        reset_n,
    dmem_resp_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    region_e       region;
    logic          store, access;
    logic [AW-1:0] ram_idx;
    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   mmio_rdata;
    logic          unused_addr;

    assign store       = |bus.dmem_writeb;
    assign access      = bus.dmem_read | store;
    assign ram_idx     = bus.dmem_addr[AW+1:2];
    assign unused_addr = ^bus.dmem_addr[1:0];

    always_comb begin
        region = RegNone;
`ifdef DMEM_MMIO_EN
        if (bus.dmem_addr[31:4] == MMIO_BASE[31:4]) begin
            case ({bus.dmem_addr[3:2], 2'b00})
                OFF_CON_TX:   region = RegConTx;
                OFF_CON_STAT: region = RegConStat;
                OFF_MTIME_LO: region = RegMtimeLo;
                default:      region = RegMtimeHi;
            endcase
        end
`endif
        if (bus.dmem_addr[31:AW+2] == RAM_BASE[31:AW+2]) region = RegRam;
    end

    assign bus.dmem_fault = access && (region == RegNone);

    always_ff @(posedge clk) begin
        if (store && region == RegRam) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dmem_writeb[i]) ram[ram_idx][8*i +: 8] <= bus.dmem_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        bus.dmem_rdata = '0;
        if (bus.dmem_read) begin
            bus.dmem_rdata = (region == RegRam) ? ram[ram_idx] : mmio_rdata;
        end
    end

`ifdef DMEM_MMIO_EN
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          ovf_q, ovf_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   con_stat;

    assign fifo_push = store && bus.dmem_writeb[0] && (region == RegConTx);
    assign fifo_pop  = !fifo_empty && bus.con_ready;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     (bus.dmem_wdata[7:0]),
        .pop     (fifo_pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bus.con_valid = !fifo_empty;
    assign bus.con_data  = fifo_empty ? 8'h00 : fifo_head;

    always_comb begin
        con_stat                                  = '0;
        con_stat[STAT_FULL]                       = fifo_full;
        con_stat[STAT_EMPTY]                      = fifo_empty;
        con_stat[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
        con_stat[STAT_OVF]                        = ovf_q;
    end

    always_comb begin
        ovf_d    = ovf_q;
        shadow_d = shadow_q;
        mtime_d  = mtime_q + 64'd1;
        if (fifo_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
        if (store && bus.dmem_writeb[0] && bus.dmem_wdata[STAT_OVF] && region == RegConStat) begin
            ovf_d = 1'b0;
        end
        if (bus.dmem_read && region == RegMtimeLo) shadow_d = mtime_q[63:32];
        // A store to either half replaces the increment for that cycle.
        if (store && region == RegMtimeLo) begin
            mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], bus.dmem_wdata, bus.dmem_writeb)};
        end
        if (store && region == RegMtimeHi) begin
            mtime_d = {merge_lanes(mtime_q[63:32], bus.dmem_wdata, bus.dmem_writeb), mtime_q[31:0]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q    <= 1'b0;
            mtime_q  <= '0;
            shadow_q <= '0;
        end else begin
            ovf_q    <= ovf_d;
            mtime_q  <= mtime_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        case (region)
            RegConStat: mmio_rdata = con_stat;
            RegMtimeLo: mmio_rdata = mtime_q[31:0];
            RegMtimeHi: mmio_rdata = shadow_q;
            default:    mmio_rdata = '0;
        endcase
    end
`else
    logic unused_con;

    assign bus.con_valid = 1'b0;
    assign bus.con_data  = '0;
    assign mmio_rdata    = '0;
    assign unused_con    = bus.con_ready ^ FIFO_DEPTH[0];
`endif
endmodule

// File: tb/tb_dmem_resp.sv
// Randomized self-checking bench for dmem_resp against a queue/array reference model.
module tb_dmem_resp;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned FD    = 4;
`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    dmem_resp_if bus ();

    dmem_resp #(
        .DEPTH_WORDS (DEPTH),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] ram_m [DEPTH];
    logic [7:0]  q_m [$];
    logic        ovf_m    = 1'b0;
    logic [63:0] mtime_m  = '0;
    logic [31:0] shadow_m = '0;

    // -2 = RAM, -1 = unmapped, otherwise MMIO byte offset
    function automatic int decode(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a < DEPTH * 4) return -2;
        if (MMIO_EN && a >= 32'h8000_0000 && a <= 32'h8000_000C) return int'(a - 32'h8000_0000);
        return -1;
    endfunction

    function automatic logic [31:0] stat_m();
        int sz;
        sz = q_m.size();
        return 32'((sz == FD) ? 1 : 0) + 32'((sz == 0) ? 2 : 0) + 32'(4 * sz) + 32'(ovf_m ? 128 : 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs are combinational, checked mid-cycle.
    always @(negedge clk) begin
        logic [31:0] er;
        logic        ef;
        int          r;
        r  = decode(bus.dmem_addr);
        ef = (bus.dmem_read || bus.dmem_writeb != 4'h0) && (r == -1);
        er = '0;
        if (bus.dmem_read) begin
            case (r)
                -2:      er = ram_m[int'(bus.dmem_addr >> 2)];
                4:       er = stat_m();
                8:       er = mtime_m[31:0];
                12:      er = shadow_m;
                default: er = '0;
            endcase
        end
        check("rdata", bus.dmem_rdata, er);
        check("fault", {31'b0, bus.dmem_fault}, {31'b0, ef});
        check("con_valid", {31'b0, bus.con_valid}, {31'b0, q_m.size() != 0});
        if (q_m.size() != 0 || !reset_n)
            check("con_data", {24'b0, bus.con_data}, {24'b0, (q_m.size() != 0) ? q_m[0] : 8'h00});
    end

    // Reference model state update.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_m.delete();
            ovf_m    = 1'b0;
            mtime_m  = '0;
            shadow_m = '0;
        end else begin
            int          r, sz, idx;
            logic [31:0] wd;
            logic [3:0]  wb;
            logic [63:0] mt_next;
            bit          pop, push;
            r       = decode(bus.dmem_addr);
            wd      = bus.dmem_wdata;
            wb      = bus.dmem_writeb;
            sz      = q_m.size();
            pop     = (sz != 0) && bus.con_ready;
            push    = 1'b0;
            mt_next = mtime_m + 64'd1;
            idx     = int'(bus.dmem_addr >> 2);
            if (r == -2) begin
                for (int i = 0; i < 4; i++) if (wb[i]) ram_m[idx][8*i +: 8] = wd[8*i +: 8];
            end
            case (r)
                0:  push = wb[0];
                4:  if (wb[0] && wd[7]) ovf_m = 1'b0;
                8: begin
                    if (bus.dmem_read) shadow_m = mtime_m[63:32];
                    if (wb != 4'h0) begin
                        mt_next = mtime_m;
                        for (int i = 0; i < 4; i++) if (wb[i]) mt_next[8*i +: 8] = wd[8*i +: 8];
                    end
                end
                12: if (wb != 4'h0) begin
                    mt_next = mtime_m;
                    for (int i = 0; i < 4; i++) if (wb[i]) mt_next[32+8*i +: 8] = wd[8*i +: 8];
                end
                default: ;
            endcase
            mtime_m = mt_next;
            if (pop) void'(q_m.pop_front());
            if (push) begin
                if (sz < FD || pop) q_m.push_back(wd[7:0]);
                else ovf_m = 1'b1;
            end
        end
    end

    task automatic set_bus(input logic r, input logic [3:0] wb, input logic [31:0] a,
                           input logic [31:0] d);
        bus.dmem_read   = r;
        bus.dmem_writeb = wb;
        bus.dmem_addr   = a;
        bus.dmem_wdata  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        bus.con_ready = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        for (int i = 0; i < int'(DEPTH); i++) begin
            set_bus(1'b0, 4'hF, 32'(i * 4), $urandom);
            tick();
        end

        // Lane-masked store merge
        set_bus(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF); tick();
        set_bus(1'b0, 4'h4, 32'h10, 32'h00AA_0000); tick();
        set_bus(1'b1, 4'h0, 32'h10, 32'h0); mid();
        check("lane_merge_rdata", bus.dmem_rdata, 32'hDEAA_BEEF);
        check("lane_merge_fault", {31'b0, bus.dmem_fault}, 32'h0);
        tick();
        set_bus(1'b1, 4'h0, 32'h13, 32'h0); mid();
        check("byte_offset_ignored", bus.dmem_rdata, 32'hDEAA_BEEF);
        tick();

        // Unmapped access and RAM edges
        set_bus(1'b0, 4'hF, 32'h0, 32'h1234_5678); tick();
        set_bus(1'b1, 4'hF, 32'h4000_0000, 32'hFFFF_FFFF); mid();
        check("unmapped_fault", {31'b0, bus.dmem_fault}, 32'h1);
        check("unmapped_rdata", bus.dmem_rdata, 32'h0);
        tick();
        set_bus(1'b1, 4'h0, 32'h0, 32'h0); mid();
        check("ram_untouched", bus.dmem_rdata, 32'h1234_5678);
        tick();
        set_bus(1'b1, 4'h0, 32'(DEPTH * 4 - 4), 32'h0); mid();
        check("last_word_fault", {31'b0, bus.dmem_fault}, 32'h0);
        tick();
        set_bus(1'b1, 4'h0, 32'(DEPTH * 4), 32'h0); mid();
        check("past_end_fault", {31'b0, bus.dmem_fault}, 32'h1);
        tick();

`ifdef DMEM_MMIO_EN
        // Overflow when pushing into a full FIFO
        for (int i = 0; i < 5; i++) begin
            set_bus(1'b0, 4'h1, 32'h8000_0000, 32'(8'h41 + i));
            tick();
        end
        set_bus(1'b1, 4'h0, 32'h8000_0004, 32'h0); mid();
        check("stat_full_ovf", bus.dmem_rdata, 32'h91);
        tick();
        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        bus.con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("drain_valid", {31'b0, bus.con_valid}, 32'h1);
            check("drain_byte", {24'b0, bus.con_data}, 32'(8'h41 + i));
            tick();
        end
        mid();
        check("drained_empty", {31'b0, bus.con_valid}, 32'h0);
        bus.con_ready = 1'b0;
        tick();
        set_bus(1'b0, 4'h1, 32'h8000_0004, 32'h80); tick();
        set_bus(1'b1, 4'h0, 32'h8000_0004, 32'h0); mid();
        check("ovf_cleared", bus.dmem_rdata, 32'h02);
        tick();

        // Push and pop together while full
        for (int i = 0; i < 4; i++) begin
            set_bus(1'b0, 4'h1, 32'h8000_0000, 32'(8'h61 + i));
            tick();
        end
        set_bus(1'b0, 4'h1, 32'h8000_0000, 32'h55);
        bus.con_ready = 1'b1;
        mid();
        check("full_pushpop_head", {24'b0, bus.con_data}, 32'h61);
        tick();
        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            mid();
            check("pushpop_order", {24'b0, bus.con_data}, (i == 3) ? 32'h55 : 32'(8'h62 + i));
            tick();
        end
        set_bus(1'b1, 4'h0, 32'h8000_0004, 32'h0); mid();
        check("pushpop_no_ovf", bus.dmem_rdata, 32'h02);
        tick();
        bus.con_ready = 1'b0;

        // Timer carry into the upper half via the shadow
        set_bus(1'b0, 4'hF, 32'h8000_0008, 32'hFFFF_FFFE); tick();
        set_bus(1'b0, 4'hF, 32'h8000_000C, 32'h0); tick();
        set_bus(1'b0, 4'h0, 32'h0, 32'h0); tick(); tick();
        set_bus(1'b1, 4'h0, 32'h8000_0008, 32'h0); mid();
        check("mtime_lo_wrap", bus.dmem_rdata, 32'h0);
        tick();
        set_bus(1'b1, 4'h0, 32'h8000_000C, 32'h0); mid();
        check("mtime_hi_shadow", bus.dmem_rdata, 32'h1);
        tick();

        // Asynchronous reset with bytes queued
        for (int i = 0; i < 3; i++) begin
            set_bus(1'b0, 4'h1, 32'h8000_0000, 32'(8'h71 + i));
            tick();
        end
        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_valid", {31'b0, bus.con_valid}, 32'h0);
        check("async_reset_data", {24'b0, bus.con_data}, 32'h0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        set_bus(1'b1, 4'h0, 32'h8000_0004, 32'h0); mid();
        check("stat_after_reset", bus.dmem_rdata, 32'h02);
        tick();
        set_bus(1'b1, 4'h0, 32'h8000_0008, 32'h0); mid();
        check("mtime_first_edge", bus.dmem_rdata, 32'h1);
        tick();
`else
        set_bus(1'b1, 4'h0, 32'h8000_0008, 32'h0); mid();
        check("mmio_off_fault", {31'b0, bus.dmem_fault}, 32'h1);
        check("mmio_off_rdata", bus.dmem_rdata, 32'h0);
        tick();
        set_bus(1'b0, 4'h1, 32'h8000_0000, 32'h41); mid();
        check("mmio_off_store_fault", {31'b0, bus.dmem_fault}, 32'h1);
        tick();
        set_bus(1'b0, 4'h0, 32'h0, 32'h0); mid();
        check("mmio_off_con_valid", {31'b0, bus.con_valid}, 32'h0);
        tick();
`endif

        for (int n = 0; n < 3000; n++) begin
            int          sel;
            logic [31:0] a;
            logic [3:0]  wb;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      a = ($urandom_range(0, DEPTH + 7) << 2) | $urandom_range(0, 3);
            else if (sel < 9) a = 32'h8000_0000 | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            else              a = $urandom;
            wb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            if (a[31] && a[3] && $urandom_range(0, 7) != 0) wb = 4'h0;
            set_bus(1'($urandom_range(0, 1)), wb, a, $urandom);
            bus.con_ready = ($urandom_range(0, 2) == 0);
            tick();
        end

        set_bus(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
